// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e      : sequencer FSM states
//   cnt_width    : width of the shared hold/stage down-counter
//   idx_width    : width of the domain index (one spare bit so it can hold N_DOMAINS)
//   params_legal : elaboration-time legality of the sequencer parameters
//   next_set     : lowest set mask bit at or above a start index, or n_domains if none
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StReset,
    StHold,
    StStage,
    StDone
  } state_e;

  localparam int unsigned MaxDomains = 16;

  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stage_delay);
    int unsigned top;
    top = (hold_cycles > stage_delay) ? hold_cycles : stage_delay;
    return $clog2(top + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n_domains);
    return $clog2(n_domains) + 1;
  endfunction

  function automatic bit params_legal(input int unsigned n_domains,
                                      input int unsigned sync_stages,
                                      input int unsigned hold_cycles,
                                      input int unsigned stage_delay);
    return (n_domains >= 1) && (n_domains <= MaxDomains) && (sync_stages >= 2) &&
           (hold_cycles >= 1) && (stage_delay >= 1);
  endfunction

  function automatic int unsigned next_set(input logic [MaxDomains-1:0] mask,
                                           input int unsigned           from,
                                           input int unsigned           n_domains);
    int unsigned            found;
    bit                     hit;
    logic [MaxDomains-1:0]  sh;
    found = n_domains;
    hit   = 1'b0;
    for (int unsigned i = 0; i < MaxDomains; i++) begin
      sh = mask >> i;
      if (!hit && (i >= from) && (i < n_domains) && sh[0]) begin
        found = i;
        hit   = 1'b1;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Load/enable down-counter shared by the HOLD and STAGE phases.
//   clk, rst_n : clock and asynchronous active-low clear
//   load       : load load_val (has priority over counting)
//   load_val   : value to load
//   en         : count down this cycle
//   expire     : count is 1 and enabled, i.e. the interval ends on this edge
module reset_seq_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = en && (count_q == CNT_W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes the board reset, holds all domains in reset
// for HOLD_CYCLES stable-clock cycles, then releases them in ascending order spaced
// STAGE_DELAY cycles apart. In DONE it accepts masked software reset requests.
//   clk, rst_n_in : clock and asynchronous active-low board reset
//   clk_stable    : PLL lock; gates the HOLD count only
//   sw_rst_req    : level request, accepted only in DONE
//   sw_rst_mask   : domains to reset, captured with the ack
//   sw_rst_ack    : one-cycle acceptance pulse
//   rst_n_out     : per-domain active-low resets (registered)
//   seq_done      : all domains released and idle
//   busy          : any state other than DONE
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGE_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 rst_n_in,
  input  logic                 clk_stable,
  input  logic                 sw_rst_req,
  input  logic [N_DOMAINS-1:0] sw_rst_mask,
  output logic                 sw_rst_ack,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 seq_done,
  output logic                 busy
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY);
  localparam int unsigned IDX_W = idx_width(N_DOMAINS);

  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] StageLoad = CNT_W'(STAGE_DELAY);
  // Index value meaning "no further domain to release".
  localparam logic [IDX_W-1:0] NoneIdx   = IDX_W'(N_DOMAINS);

  if (!params_legal(N_DOMAINS, SYNC_STAGES, HOLD_CYCLES, STAGE_DELAY)) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rel;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_DOMAINS-1:0]   mask_q, mask_d;
  logic [N_DOMAINS-1:0]   rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;

  logic                   hold_phase;
  logic                   tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0]       tmr_val;
  logic                   advance, rel_dom, drop, accept;
  logic [MaxDomains-1:0]  mask_ext;
  logic [IDX_W-1:0]       nxt_idx;
  logic [N_DOMAINS-1:0]   rel_vec;

  // Reset synchronizer: asynchronous assert, synchronous release.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel = sync_q[SYNC_STAGES-1];

  // The first cycle with the synchronizer released already counts as a HOLD cycle,
  // so domain 0 releases on edge SYNC_STAGES + HOLD_CYCLES.
  assign hold_phase = (state_q == StHold) || ((state_q == StReset) && sync_rel);
  assign tmr_en     = (state_q == StStage) || (hold_phase && clk_stable);

  assign mask_ext = MaxDomains'(mask_q);
  assign nxt_idx  = IDX_W'(next_set(mask_ext, 32'(idx_q) + 1, N_DOMAINS));
  assign rel_vec  = N_DOMAINS'(1) << idx_q;

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n_in),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StReset;
      idx_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. idx_q always points at the next domain to release; mask_q
  // holds the active set (all ones after power-up, the captured mask after a request).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    tmr_load = 1'b0;
    tmr_val  = HoldLoad;
    advance  = 1'b0;
    drop     = 1'b0;

    unique case (state_q)
      StReset, StHold: begin
        if (!hold_phase) begin
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
        end else begin
          state_d = StHold;
          advance = tmr_expire;
        end
      end
      StStage: begin
        advance = tmr_expire;
      end
      StDone: begin
        // ack_q marks the cycle after acceptance; a zero mask leaves us in DONE.
        if (ack_q && (mask_q != '0)) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
          idx_d    = IDX_W'(next_set(mask_ext, 0, N_DOMAINS));
          drop     = 1'b1;
        end
      end
      default: state_d = StReset;
    endcase

    rel_dom = advance;
    if (advance) begin
      if (nxt_idx == NoneIdx) begin
        state_d = StDone;
      end else begin
        state_d  = StStage;
        idx_d    = nxt_idx;
        tmr_load = 1'b1;
        tmr_val  = StageLoad;
      end
    end

    // Accept on the first cycle spent in DONE; !ack_q keeps each ack to one cycle.
    accept = sw_rst_req && (state_d == StDone) && !ack_q;
    if (accept) begin
      mask_d = sw_rst_mask;
    end
  end

  // Registered output values.
  always_comb begin
    rst_d = rst_q;
    if (rel_dom) begin
      rst_d = rst_q | rel_vec;
    end
    if (drop) begin
      rst_d = rst_q & ~mask_q;
    end
    done_d = (state_d == StDone);
    busy_d = (state_d != StDone);
    ack_d  = accept;
  end

  assign rst_n_out  = rst_q;
  assign seq_done   = done_q;
  assign sw_rst_ack = ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Expected release edges are computed from
// the timing rules: first release at SYNC + HOLD (+ clock-unstable cycles), then one
// active domain every STAGE_DELAY edges in ascending order.
module tb_reset_sequencer;

  localparam int N = 4;
  localparam int S = 2;
  localparam int H = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n_in;
  logic         clk_stable;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic         sw_rst_ack;
  logic [N-1:0] rst_n_out;
  logic         seq_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_DOMAINS   (N),
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H),
    .STAGE_DELAY (D)
  ) dut (
    .clk         (clk),
    .rst_n_in    (rst_n_in),
    .clk_stable  (clk_stable),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_mask (sw_rst_mask),
    .sw_rst_ack  (sw_rst_ack),
    .rst_n_out   (rst_n_out),
    .seq_done    (seq_done),
    .busy        (busy)
  );

  // Asserts rst_n_in mid-cycle, checks the asynchronous response, then releases it
  // on a falling edge so that the next rising edge is edge 1.
  task automatic test_reset();
    @(posedge clk);
    #3;
    rst_n_in   = 1'b0;
    clk_stable = 1'b1;
    sw_rst_req = 1'b0;
    #1;
    checks++;
    if (rst_n_out !== '0) begin
      errors++;
      $display("FAIL reset_async_rst got %b want %b", rst_n_out, {N{1'b0}});
    end
    checks++;
    if ({seq_done, busy, sw_rst_ack} !== 3'b010) begin
      errors++;
      $display("FAIL reset_async_flags got %b want 010", {seq_done, busy, sw_rst_ack});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rst_n_out !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_held got %b/%b want %b/1", rst_n_out, busy, {N{1'b0}});
    end
    @(negedge clk);
    rst_n_in = 1'b1;
  endtask

  // Follows the power-up timeline edge by edge; clk_stable is low on edges
  // [stall_start, stall_start + stall_len) when stall_start > 0.
  task automatic test_powerup(input int stall_start, input int stall_len);
    int           rel0;
    int           last;
    logic [N-1:0] exp_rst;
    logic         exp_done;
    rel0 = S + H + ((stall_start > 0) ? stall_len : 0);
    last = rel0 + (N - 1) * D;
    for (int e = 1; e <= last + 3; e++) begin
      clk_stable = !(stall_start > 0 && e >= stall_start && e < stall_start + stall_len);
      @(posedge clk);
      #1;
      exp_rst = '0;
      for (int i = 0; i < N; i++) begin
        if (e >= rel0 + i * D) exp_rst = exp_rst | (N'(1) << i);
      end
      exp_done = (e >= last);
      checks++;
      if (rst_n_out !== exp_rst) begin
        errors++;
        $display("FAIL powerup_rst edge %0d got %b want %b", e, rst_n_out, exp_rst);
      end
      checks++;
      if ({seq_done, busy, sw_rst_ack} !== {exp_done, !exp_done, 1'b0}) begin
        errors++;
        $display("FAIL powerup_flags edge %0d got %b want %b", e,
                 {seq_done, busy, sw_rst_ack}, {exp_done, !exp_done, 1'b0});
      end
    end
    clk_stable = 1'b1;
  endtask

  // Software reset of a nonzero mask from DONE.
  task automatic test_sw_mask(input logic [N-1:0] m);
    int           cnt;
    int           last;
    int           k;
    logic [N-1:0] exp_rst;
    logic         exp_done;
    sw_rst_req  = 1'b1;
    sw_rst_mask = m;
    @(posedge clk);
    #1;
    checks++;
    if (sw_rst_ack !== 1'b1 || rst_n_out !== '1 || seq_done !== 1'b1) begin
      errors++;
      $display("FAIL sw_ack got ack=%b rst=%b done=%b want ack=1 rst=1111 done=1",
               sw_rst_ack, rst_n_out, seq_done);
    end
    sw_rst_req  = 1'b0;
    sw_rst_mask = N'($urandom);
    @(posedge clk);
    #1;
    checks++;
    if (rst_n_out !== ~m || {seq_done, busy, sw_rst_ack} !== 3'b010) begin
      errors++;
      $display("FAIL sw_drop got rst=%b flags=%b want rst=%b flags=010",
               rst_n_out, {seq_done, busy, sw_rst_ack}, ~m);
    end
    cnt  = $countones(m);
    last = H + (cnt - 1) * D;
    for (int e = 1; e <= last + 3; e++) begin
      @(posedge clk);
      #1;
      exp_rst = ~m;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (((m >> i) & N'(1)) != '0) begin
          if (e >= H + k * D) exp_rst = exp_rst | (N'(1) << i);
          k++;
        end
      end
      exp_done = (e >= last);
      checks++;
      if (rst_n_out !== exp_rst) begin
        errors++;
        $display("FAIL sw_release mask %b edge %0d got %b want %b", m, e, rst_n_out, exp_rst);
      end
      checks++;
      if ({seq_done, busy, sw_rst_ack} !== {exp_done, !exp_done, 1'b0}) begin
        errors++;
        $display("FAIL sw_flags mask %b edge %0d got %b want %b", m, e,
                 {seq_done, busy, sw_rst_ack}, {exp_done, !exp_done, 1'b0});
      end
    end
  endtask

  task automatic test_mask_zero();
    sw_rst_req  = 1'b1;
    sw_rst_mask = '0;
    @(posedge clk);
    #1;
    checks++;
    if (sw_rst_ack !== 1'b1) begin
      errors++;
      $display("FAIL zero_ack got %b want 1", sw_rst_ack);
    end
    sw_rst_req = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rst_n_out !== '1 || {seq_done, busy, sw_rst_ack} !== 3'b100) begin
        errors++;
        $display("FAIL zero_hold edge %0d got rst=%b flags=%b want rst=1111 flags=100",
                 e, rst_n_out, {seq_done, busy, sw_rst_ack});
      end
    end
  endtask

  // Request raised at edge 30 of power-up stays pending until the first DONE cycle.
  task automatic test_pending_req(input logic [N-1:0] m);
    int done_edge;
    done_edge = S + H + (N - 1) * D;
    clk_stable = 1'b1;
    for (int e = 1; e <= done_edge; e++) begin
      if (e == 30) begin
        sw_rst_req  = 1'b1;
        sw_rst_mask = m;
      end
      @(posedge clk);
      #1;
      checks++;
      if (sw_rst_ack !== (e == done_edge)) begin
        errors++;
        $display("FAIL pending_ack edge %0d got %b want %b", e, sw_rst_ack, e == done_edge);
      end
    end
    checks++;
    if (seq_done !== 1'b1) begin
      errors++;
      $display("FAIL pending_done got %b want 1", seq_done);
    end
    sw_rst_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rst_n_out !== ~m || sw_rst_ack !== 1'b0) begin
      errors++;
      $display("FAIL pending_drop got rst=%b ack=%b want rst=%b ack=0",
               rst_n_out, sw_rst_ack, ~m);
    end
  endtask

  // Board reset pulsed mid-STAGE; the timeline must restart from scratch.
  task automatic test_async_reset();
    int mid;
    test_reset();
    mid = int'($urandom_range(11, 55));
    clk_stable = 1'b1;
    repeat (mid) @(posedge clk);
    test_reset();
    test_powerup(0, 0);
  endtask

  initial begin
    rst_n_in    = 1'b1;
    clk_stable  = 1'b1;
    sw_rst_req  = 1'b0;
    sw_rst_mask = '0;

    test_reset();
    test_powerup(0, 0);
    test_sw_mask(4'b1010);
    test_sw_mask(N'($urandom_range(1, (1 << N) - 1)));
    test_sw_mask(N'($urandom_range(1, (1 << N) - 1)));
    test_mask_zero();

    test_reset();
    test_powerup(int'($urandom_range(3, 10)), 20);

    test_reset();
    test_pending_req(N'($urandom_range(1, (1 << N) - 1)));

    test_async_reset();
    test_sw_mask(N'($urandom_range(1, (1 << N) - 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
